// File: rtl/inv_aes_128_iter_pkg.sv
// Shared definitions for the iterative AES-128 decipher: round count, rcon constants,
// FSM states and the GF(2^8)/byte-transform helper functions.
package inv_aes_128_iter_pkg;

  localparam int unsigned AES_ROUNDS = 10;
  localparam logic [7:0]  RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_ROUND, ST_DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_prev(input logic [7:0] r);
    return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

  function automatic logic [7:0] rcon_next(input logic [7:0] r);
    return xtime(r);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] e;
    r = 8'h01;
    x = a;
    e = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, x);
      x = gf_mul(x, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = gf_inv(a);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n sits at [127-8n -: 8]; column c holds bytes 4c..4c+3, row r is the byte within it.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] evolve_key_128(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/inv_aes_128_iter_key_step.sv
// Reverse AES-128 key schedule step: derives round key k(i-1) from k(i) and its rcon.
module inv_key_step_128
  import inv_aes_128_iter_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rconst,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;

  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;
  assign n0 = w0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rconst, 24'h0};

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/inv_aes_128_iter.sv
// Iterative AES-128 decipher, one inverse round per clock, valid/ready on both sides.
// Define INV_AES_KEY_EXPAND_EN to accept the cipher key k0 and expand it to k10 internally.
module inv_aes_128_iter
  import inv_aes_128_iter_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] dat_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dat_out
);

  state_t       state, state_nxt;
  logic [127:0] st, rk, rk_prev, rnd_sub, rnd_mix;
  logic [7:0]   rcon;
  logic [3:0]   rnd;

  inv_key_step_128 u_key_step (
    .key_in  (rk),
    .rconst  (rcon),
    .key_out (rk_prev)
  );

  assign rnd_sub = inv_sub_bytes(inv_shift_rows(st)) ^ rk_prev;
  assign rnd_mix = inv_mix_columns(rnd_sub);

`ifdef INV_AES_KEY_EXPAND_EN
  logic [127:0] rk_fwd;
  assign rk_fwd = evolve_key_128(rk, rcon);
`endif

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
`ifdef INV_AES_KEY_EXPAND_EN
        if (in_valid) state_nxt = ST_EXPAND;
`else
        if (in_valid) state_nxt = ST_ROUND;
`endif
      end
      ST_EXPAND: if (rnd == 4'd0) state_nxt = ST_ROUND;
      ST_ROUND:  if (rnd == 4'd0) state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st        <= '0;
      rk        <= '0;
      rcon      <= '0;
      rnd       <= '0;
      dat_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rk  <= key_in;
            rnd <= 4'(AES_ROUNDS - 1);
`ifdef INV_AES_KEY_EXPAND_EN
            st   <= dat_in;
            rcon <= 8'h01;
`else
            st   <= dat_in ^ key_in;
            rcon <= RCON_LAST;
`endif
          end
        end
`ifdef INV_AES_KEY_EXPAND_EN
        // The tenth forward step yields k10, which also whitens the stored ciphertext.
        ST_EXPAND: begin
          rk <= rk_fwd;
          if (rnd == 4'd0) begin
            st   <= st ^ rk_fwd;
            rcon <= RCON_LAST;
            rnd  <= 4'(AES_ROUNDS - 1);
          end else begin
            rcon <= rcon_next(rcon);
            rnd  <= rnd - 4'd1;
          end
        end
`endif
        ST_ROUND: begin
          rk   <= rk_prev;
          rcon <= rcon_prev(rcon);
          if (rnd == 4'd0) begin
            dat_out   <= rnd_sub;
            out_valid <= 1'b1;
          end else begin
            st  <= rnd_mix;
            rnd <= rnd - 4'd1;
          end
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_aes_128_iter.sv
// Self-checking bench for inv_aes_128_iter: FIPS-197 vectors, backpressure, abort, and a
// stream checked against a forward AES-128 reference model (honours INV_AES_KEY_EXPAND_EN).
module tb_inv_aes_128_iter;

`ifdef INV_AES_KEY_EXPAND_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 10;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] dat_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] dat_out;

  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb[256];

  logic         prev_ov = 1'b0, prev_or = 1'b0, prev_hs = 1'b0;
  logic [127:0] prev_dat = '0;

  inv_aes_128_iter dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dat_in    (dat_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dat_out   (dat_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: forward AES-128, S-box built by the generator walk rather than inversion.
  function automatic logic [7:0] rl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] expand_k10(input logic [127:0] k0);
    logic [127:0] k;
    logic [7:0]   rc;
    k = k0;
    rc = 8'h01;
    for (int r = 0; r < 10; r++) begin
      k = key_next(k, rc);
      rc = x2(rc);
    end
    return k;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k0);
    logic [7:0]   b[16];
    logic [7:0]   o[16];
    logic [127:0] k, s;
    logic [7:0]   rc, a0, a1, a2, a3;
    k = k0;
    s = pt ^ k0;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k = key_next(k, rc);
      rc = x2(rc);
      for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) o[4*c+w] = b[4*((c+w)%4)+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
          o[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
          o[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
          o[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
          o[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = o[i];
      s = s ^ k;
    end
    return s;
  endfunction

  function automatic logic [127:0] dut_key(input logic [127:0] k0, input logic [127:0] k10);
`ifdef INV_AES_KEY_EXPAND_EN
    return k0;
`else
    return k10;
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+#1; with noise, in_valid stays high with junk while the DUT is busy.
  task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                      input bit noise);
    int unsigned w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_timeout", {127'b0, in_ready}, 128'd1);
    if (!in_ready) return;
    dat_in   = ct;
    key_in   = key;
    in_valid = 1'b1;
    exp_q.push_back(pt);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (noise) begin
      dat_in = rand128();
      key_in = rand128();
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
      if (in_ready) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (out_valid && !prev_ov) check("latency", 128'(cyc - acc_cyc), 128'(LAT));
      if (out_valid) check("busy_ready", {127'b0, in_ready}, 128'd0);
      if (prev_ov && !prev_or) begin
        check("hold_valid", {127'b0, out_valid}, 128'd1);
        check("hold_data", dat_out, prev_dat);
      end
      if (prev_hs) begin
        check("ready_after", {127'b0, in_ready}, 128'd1);
        check("valid_after", {127'b0, out_valid}, 128'd0);
      end
      if (out_valid && out_ready) begin
        check("queue_nonempty", {127'b0, exp_q.size() != 0}, 128'd1);
        if (exp_q.size() != 0) check("data", dat_out, exp_q.pop_front());
      end
    end
    prev_ov  = out_valid;
    prev_or  = out_ready;
    prev_hs  = out_valid && out_ready && !clr;
    prev_dat = dat_out;
  end

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] pt1, k01, k101, ct1, pt2, k02, k102, ct2, pt, k0, ct;
    bit           seen;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;

    pt1  = 128'h3243f6a8885a308d313198a2e0370734;
    k01  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k101 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    ct1  = 128'h3925841d02dc09fbdc118597196a0b32;
    pt2  = 128'h00112233445566778899aabbccddeeff;
    k02  = 128'h000102030405060708090a0b0c0d0e0f;
    k102 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    ct2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    check("rst_in_ready", {127'b0, in_ready}, 128'd1);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_dat_out", dat_out, 128'd0);

    send(ct1, dut_key(k01, k101), pt1, 1'b0);
    drain();
    send(ct2, dut_key(k02, k102), pt2, 1'b0);
    drain();

    out_ready = 1'b0;
    send(ct2, dut_key(k02, k102), pt2, 1'b0);
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid", {127'b0, out_valid}, 128'd1);
    repeat (7) @(posedge clk);
    #1;
    check("bp_ready", {127'b0, in_ready}, 128'd0);
    check("bp_data", dat_out, pt2);
    out_ready = 1'b1;
    drain();

    send(ct1, dut_key(k01, k101), pt1, 1'b0);
    repeat (LAT / 2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    exp_q.delete();
    check("clr_ready", {127'b0, in_ready}, 128'd1);
    check("clr_valid", {127'b0, out_valid}, 128'd0);
    check("clr_dat", dat_out, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("clr_no_out", {127'b0, seen}, 128'd0);
    send(ct1, dut_key(k01, k101), pt1, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) begin
      pt = rand128();
      k0 = rand128();
      ct = aes_enc(pt, k0);
      send(ct, dut_key(k0, expand_k10(k0)), pt, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
